// File: rtl/pick_frame_scanner.sv
// pick_frame_scanner: per-frame showPick3 bounding box, count and overlap summary with a valid/ready result port
module pick_frame_scanner #(
  parameter int X_MAX = 639,
  parameter int Y_MAX = 479
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic        pixel_valid,
  input  logic [9:0]  drawX,
  input  logic [9:0]  drawY,
  input  logic        showPick2,
  input  logic        showPick3,
  input  logic        res_ready,
  output logic        res_valid,
  output logic [9:0]  minX,
  output logic [9:0]  maxX,
  output logic [9:0]  minY,
  output logic [9:0]  maxY,
  output logic [18:0] p3_count,
  output logic        overlap,
  output logic        empty,
  output logic        overrun
);
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic [9:0] XM = 10'(X_MAX);
  localparam logic [9:0] YM = 10'(Y_MAX);
  state_t state_q, state_d;
  logic [9:0] aminx_q, amaxx_q, aminy_q, amaxy_q;
  logic [9:0] aminx_d, amaxx_d, aminy_d, amaxy_d;
  logic [18:0] acnt_q, acnt_d;
  logic aovl_q, aovl_d, drop_q;
  logic [9:0] bminx, bmaxx, bminy, bmaxy, uminx, umaxx, uminy, umaxy;
  logic [18:0] bcnt, ucnt;
  logic bovl, uovl, commit, fresh, hit, load;
  // Fold the current pixel into either the running or a freshly cleared frame; pick next state.
  always_comb begin
    commit  = state_q == SCAN && frame_end;
    fresh   = frame_start && !commit;
    hit     = (state_q == SCAN || frame_start) && pixel_valid && drawX <= XM && drawY <= YM && showPick3;
    load    = commit && (!res_valid || res_ready);
    bminx   = fresh ? 10'd1023 : aminx_q;
    bmaxx   = fresh ? 10'd0 : amaxx_q;
    bminy   = fresh ? 10'd1023 : aminy_q;
    bmaxy   = fresh ? 10'd0 : amaxy_q;
    bcnt    = fresh ? 19'd0 : acnt_q;
    bovl    = fresh ? 1'b0 : aovl_q;
    uminx   = hit && drawX < bminx ? drawX : bminx;
    umaxx   = hit && drawX > bmaxx ? drawX : bmaxx;
    uminy   = hit && drawY < bminy ? drawY : bminy;
    umaxy   = hit && drawY > bmaxy ? drawY : bmaxy;
    ucnt    = hit && bcnt != '1 ? bcnt + 19'd1 : bcnt;
    uovl    = bovl | (hit & showPick2);
    aminx_d = commit && frame_start ? 10'd1023 : uminx;
    amaxx_d = commit && frame_start ? 10'd0 : umaxx;
    aminy_d = commit && frame_start ? 10'd1023 : uminy;
    amaxy_d = commit && frame_start ? 10'd0 : umaxy;
    acnt_d  = commit && frame_start ? 19'd0 : ucnt;
    aovl_d  = commit && frame_start ? 1'b0 : uovl;
    state_d = frame_start ? SCAN : commit ? IDLE : state_q;
  end
  // State and accumulator registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      aminx_q <= 10'd1023;
      amaxx_q <= 10'd0;
      aminy_q <= 10'd1023;
      amaxy_q <= 10'd0;
      acnt_q  <= 19'd0;
      aovl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      aminx_q <= aminx_d;
      amaxx_q <= amaxx_d;
      aminy_q <= aminy_d;
      amaxy_q <= amaxy_d;
      acnt_q  <= acnt_d;
      aovl_q  <= aovl_d;
    end
  end
  // Result port: load on an accepted commit, otherwise record a drop or retire a consumed result.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      res_valid <= 1'b0;
      minX      <= 10'd1023;
      maxX      <= 10'd0;
      minY      <= 10'd1023;
      maxY      <= 10'd0;
      p3_count  <= 19'd0;
      overlap   <= 1'b0;
      overrun   <= 1'b0;
      drop_q    <= 1'b0;
    end else if (load) begin
      res_valid <= 1'b1;
      minX      <= uminx;
      maxX      <= umaxx;
      minY      <= uminy;
      maxY      <= umaxy;
      p3_count  <= ucnt;
      overlap   <= uovl;
      overrun   <= drop_q;
      drop_q    <= 1'b0;
    end else if (commit) begin
      drop_q    <= 1'b1;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end
  assign empty = p3_count == 19'd0;
endmodule

// File: tb/tb_pick_frame_scanner.sv
// tb_pick_frame_scanner: scoreboard bench for pick_frame_scanner
module tb_pick_frame_scanner;
  logic CLK = 0, Reset = 1, frame_start = 0, frame_end = 0, pixel_valid = 0;
  logic [9:0] drawX = 0, drawY = 0;
  logic showPick2 = 0, showPick3 = 0, res_ready = 0;
  logic res_valid, overlap, empty, overrun;
  logic [9:0] minX, maxX, minY, maxY;
  logic [18:0] p3_count;
  int checks = 0, errors = 0;
  typedef struct {int mnx; int mxx; int mny; int mxy; int cnt; int ovl; int emp; int ovr;} res_t;
  res_t q[$];

  pick_frame_scanner dut (
    .CLK(CLK), .Reset(Reset), .frame_start(frame_start), .frame_end(frame_end),
    .pixel_valid(pixel_valid), .drawX(drawX), .drawY(drawY),
    .showPick2(showPick2), .showPick3(showPick3), .res_ready(res_ready),
    .res_valid(res_valid), .minX(minX), .maxX(maxX), .minY(minY), .maxY(maxY),
    .p3_count(p3_count), .overlap(overlap), .empty(empty), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic res_t mk(int mnx, int mxx, int mny, int mxy, int cnt, int ovl, int emp, int ovr);
    res_t r;
    r.mnx = mnx; r.mxx = mxx; r.mny = mny; r.mxy = mxy;
    r.cnt = cnt; r.ovl = ovl; r.emp = emp; r.ovr = ovr;
    return r;
  endfunction

  task automatic step(input int x, input int y, input bit pv, input bit p2, input bit p3, input bit fs, input bit fe);
    drawX = 10'(x); drawY = 10'(y); pixel_valid = pv;
    showPick2 = p2; showPick3 = p3; frame_start = fs; frame_end = fe;
    @(posedge CLK); #1;
    pixel_valid = 0; showPick2 = 0; showPick3 = 0; frame_start = 0; frame_end = 0;
  endtask

  task automatic check_result(input string tag, input res_t r);
    chk({tag, "_valid"}, int'(res_valid), 1);
    chk({tag, "_minX"}, int'(minX), r.mnx);
    chk({tag, "_maxX"}, int'(maxX), r.mxx);
    chk({tag, "_minY"}, int'(minY), r.mny);
    chk({tag, "_maxY"}, int'(maxY), r.mxy);
    chk({tag, "_count"}, int'(p3_count), r.cnt);
    chk({tag, "_overlap"}, int'(overlap), r.ovl);
    chk({tag, "_empty"}, int'(empty), r.emp);
    chk({tag, "_overrun"}, int'(overrun), r.ovr);
  endtask

  task automatic consume(input string tag);
    res_t r;
    int n = 0;
    while (!res_valid && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!res_valid) begin
      chk({tag, "_timeout"}, 0, 1);
      if (q.size() > 0) void'(q.pop_front());
    end else if (q.size() == 0) begin
      chk({tag, "_unexpected"}, 1, 0);
    end else begin
      r = q.pop_front();
      check_result(tag, r);
      res_ready = 1;
      @(posedge CLK); #1;
      res_ready = 0;
      chk({tag, "_retired"}, int'(res_valid), 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_count", int'(p3_count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_minX", int'(minX), 1023);
    chk("rst_maxY", int'(maxY), 0);
    chk("rst_overrun", int'(overrun), 0);
    Reset = 0;
    @(posedge CLK); #1;

    // basic frame; last hit lands on the frame_end cycle
    step(0, 0, 0, 0, 0, 1, 0);
    step(100, 50, 1, 0, 1, 0, 0);
    step(120, 60, 1, 0, 1, 0, 0);
    step(110, 55, 1, 0, 1, 0, 1);
    chk("basic_latency", int'(res_valid), 1);
    q.push_back(mk(100, 120, 50, 60, 3, 0, 0, 0));
    consume("basic");

    // overlap on the frame_start cycle, out-of-range pixel ignored
    step(10, 10, 1, 1, 1, 1, 0);
    step(700, 10, 1, 0, 1, 0, 0);
    step(30, 30, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    q.push_back(mk(10, 10, 10, 10, 1, 1, 0, 0));
    consume("ovl");

    // coordinate limits and pixel_valid gating
    step(0, 0, 0, 0, 0, 1, 0);
    step(639, 479, 1, 0, 1, 0, 0);
    step(640, 5, 1, 0, 1, 0, 0);
    step(5, 480, 1, 0, 1, 0, 0);
    step(3, 3, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    q.push_back(mk(639, 639, 479, 479, 1, 0, 0, 0));
    consume("edge");

    // backpressure: A held, B dropped, C reports overrun, D clean
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 2, 1, 0, 1, 0, 1);
    check_result("bp_a", mk(1, 1, 2, 2, 1, 0, 0, 0));
    step(0, 0, 0, 0, 0, 1, 0);
    step(3, 4, 1, 0, 1, 0, 1);
    @(posedge CLK); #1;
    check_result("bp_hold", mk(1, 1, 2, 2, 1, 0, 0, 0));
    q.push_back(mk(1, 1, 2, 2, 1, 0, 0, 0));
    consume("bp_acc");
    step(0, 0, 0, 0, 0, 1, 0);
    step(7, 8, 1, 0, 1, 0, 1);
    q.push_back(mk(7, 7, 8, 8, 1, 0, 0, 1));
    consume("bp_c");
    step(0, 0, 0, 0, 0, 1, 0);
    step(9, 9, 1, 0, 1, 0, 1);
    q.push_back(mk(9, 9, 9, 9, 1, 0, 0, 0));
    consume("bp_d");

    // simultaneous start/end: pixel joins the old frame only
    step(0, 0, 0, 0, 0, 1, 0);
    step(20, 30, 1, 0, 1, 0, 0);
    step(5, 5, 1, 0, 1, 1, 1);
    q.push_back(mk(5, 20, 5, 30, 2, 0, 0, 0));
    consume("se_old");
    step(50, 60, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    q.push_back(mk(50, 50, 60, 60, 1, 0, 0, 0));
    consume("se_new");

    // abort then empty frame
    step(0, 0, 0, 0, 0, 1, 0);
    step(30, 30, 1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(40, 40, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    q.push_back(mk(1023, 0, 1023, 0, 0, 0, 1, 0));
    consume("empty");

    // reset mid-SCAN with a pending result
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 1, 0, 1, 0, 1);
    chk("rstm_pending", int'(res_valid), 1);
    step(0, 0, 0, 0, 0, 1, 0);
    Reset = 1;
    step(2, 2, 1, 0, 1, 0, 1);
    Reset = 0;
    chk("rstm_valid", int'(res_valid), 0);
    chk("rstm_count", int'(p3_count), 0);
    step(0, 0, 0, 0, 0, 0, 1);
    repeat (3) @(posedge CLK);
    #1;
    chk("rstm_idle_end", int'(res_valid), 0);
    chk("rstm_overrun", int'(overrun), 0);
    chk("sb_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
